// File: rtl/uart_baud_pkg.sv
// Shared constants and types for the UART baud tick generator.
package uart_baud_pkg;

    localparam int BAUD_CNT_W    = 16;
    localparam int BAUD_FRAC_W   = 4;
    localparam int MIN_DIV       = 2;
    localparam int BAUD_DEF_INT  = 651;
    localparam int BAUD_DEF_FRAC = 0;
    localparam int BAUD_OVS      = 16;

    typedef struct packed {
        logic [BAUD_CNT_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } div_cfg_t;

endpackage

// File: rtl/baud_tick_generator_if.sv
// Divisor configuration handshake between the register block and the baud generator.
interface baud_tick_generator_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;

    modport master (output cfg_valid, output cfg_int, output cfg_frac, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_int, input cfg_frac, output cfg_ready);

endinterface

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator; only exists when BAUD_FRAC_EN is defined.
`ifdef BAUD_FRAC_EN
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              os_tick,
    input  logic [FRAC_W-1:0] cur_frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;

    // The overflow of each tick's add stretches the following period by one cycle.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (os_tick) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, cur_frac};
        end
    end

endmodule
`endif

// File: rtl/baud_tick_generator.sv
// Programmable UART baud tick generator (oversample, bit-centre and bit-end ticks).
// Define BAUD_FRAC_EN to enable the fractional divisor accumulator.
module baud_tick_generator
    import uart_baud_pkg::*;
#(
    parameter int CNT_W    = BAUD_CNT_W,
    parameter int FRAC_W   = BAUD_FRAC_W,
    parameter int OVS      = BAUD_OVS,
    parameter int DEF_INT  = BAUD_DEF_INT,
    parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    baud_tick_generator_if.slave  cfg,
    output logic                  os_tick,
    output logic                  mid_tick,
    output logic                  bit_tick
);

    localparam int OS_W = $clog2(OVS);
    localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]  OS_MID     = OS_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] DEF_INT_CL = (DEF_INT < MIN_DIV) ? CNT_W'(MIN_DIV) : CNT_W'(DEF_INT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_int;
    logic [CNT_W-1:0] pend_int;
    logic [CNT_W-1:0] cfg_int_cl;
    logic [CNT_W:0]   plen_m1;
    logic [OS_W-1:0]  os_cnt;
    logic             pending;
    logic             carry;
    logic             terminal;
    logic             apply;

    // Extra bit keeps int + carry from wrapping at the largest divisor.
    assign plen_m1    = {1'b0, cur_int} + (CNT_W+1)'(carry) - (CNT_W+1)'(1);
    assign terminal   = ({1'b0, cnt} >= plen_m1);
    assign os_tick    = en && !sync && terminal;
    assign mid_tick   = os_tick && (os_cnt == OS_MID);
    assign bit_tick   = os_tick && (os_cnt == OS_LAST);
    assign apply      = pending && (os_tick || sync || !en);
    assign cfg_int_cl = (cfg.cfg_int < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg.cfg_int;
    assign cfg.cfg_ready = !pending;

    // Terminal test is >= so a shorter divisor applied while paused cannot strand cnt past the end.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (en) begin
            if (terminal) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (os_tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            pend_int <= DEF_INT_CL;
            cur_int  <= DEF_INT_CL;
        end else if (apply) begin
            pending <= 1'b0;
            cur_int <= pend_int;
        end else if (cfg.cfg_valid && !pending) begin
            pending  <= 1'b1;
            pend_int <= cfg_int_cl;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] cur_frac;
    logic [FRAC_W-1:0] pend_frac;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_frac <= FRAC_W'(DEF_FRAC);
            cur_frac  <= FRAC_W'(DEF_FRAC);
        end else if (apply) begin
            cur_frac <= pend_frac;
        end else if (cfg.cfg_valid && !pending) begin
            pend_frac <= cfg.cfg_frac;
        end
    end

    baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .os_tick  (os_tick),
        .cur_frac (cur_frac),
        .carry    (carry)
    );
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{cfg.cfg_frac, FRAC_W'(DEF_FRAC)};
`endif

endmodule
